// File: rtl/pent_pkg.sv
// Shared constants and helpers for the Pentagon memory pager.
// Covers ROM bank codes, port/trap addresses and RAM page width.
package pent_pkg;

  localparam logic [1:0] ROM128 = 2'd0;
  localparam logic [1:0] ROM48  = 2'd1;
  localparam logic [1:0] ROMDOS = 2'd2;

  localparam logic [15:0] PORT_7FFD = 16'h7FFD;
  localparam logic [7:0]  DOS_HI    = 8'h3D;

  function automatic int page_bits(input int ram_kb);
    case (ram_kb)
      128:     return 3;
      256:     return 4;
      1024:    return 6;
      default: return 5;
    endcase
  endfunction

endpackage

// File: rtl/pent_mem_pager_if.sv
// CPU-side bus of the pager: Z80 address/data/strobes in,
// memory mapping results out.
interface pent_mem_pager_if #(
  parameter int RAM_KB = 512
);
  import pent_pkg::*;

  localparam int PAGE_BITS = page_bits(RAM_KB);

  logic [15:0]          A;
  logic [7:0]           D;
  logic                 CPU_IORQ;
  logic                 CPU_WR;
  logic                 CPU_MREQ;
  logic                 CPU_M1;
  logic [PAGE_BITS-1:0] PAGE;
  logic                 RAM_SEL;
  logic [1:0]           ROM_BANK;
  logic                 SCREEN;
  logic                 DOS;
  logic                 LOCKED;

  modport master (
    output A, D, CPU_IORQ, CPU_WR,
    output CPU_MREQ, CPU_M1,
    input  PAGE, RAM_SEL, ROM_BANK,
    input  SCREEN, DOS, LOCKED
  );

  modport slave (
    input  A, D, CPU_IORQ, CPU_WR,
    input  CPU_MREQ, CPU_M1,
    output PAGE, RAM_SEL, ROM_BANK,
    output SCREEN, DOS, LOCKED
  );

endinterface

// File: rtl/pent_sync_edge.sv
// Two-flop synchroniser on a strobe group plus a one-clock
// pulse when the group enters its ACTIVE pattern.
module pent_sync_edge #(
  parameter int           W      = 2,
  parameter logic [W-1:0] ACTIVE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] strb,
  output logic         pulse
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         act_q;
  logic         act;

  assign act = (s2 == ACTIVE);

  // Reset parks the chain in the asserted state, so a strobe
  // still held low after reset never looks like a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= ACTIVE;
      s2    <= ACTIVE;
      act_q <= 1'b1;
    end else begin
      s1    <= strb;
      s2    <= s1;
      act_q <= act;
    end
  end

  assign pulse = act && !act_q;

endmodule

// File: rtl/pent_mem_pager.sv
// Pentagon 7FFD memory pager with TR-DOS shadow ROM trap.
// Registers are updated from synchronised Z80 strobe events.
module pent_mem_pager
  import pent_pkg::*;
#(
  parameter int RAM_KB      = 512,
  parameter int FULL_DECODE = 0
) (
  input logic             CLK_14MHZ,
  input logic             RESET,
  pent_mem_pager_if.slave bus
);

  localparam int PAGE_BITS = page_bits(RAM_KB);

  logic       io_ev;
  logic       fetch_ev;
  logic [2:0] bank;
  logic [2:0] ext;
  logic       rom;
  logic       screen;
  logic       locked;
  logic       dos;
  logic [2:0] ext_d;
  logic       lock_d;
  logic       port_hit;
  logic       wr_en;
  logic [5:0] page_hi;

  logic [PAGE_BITS-1:0] page_q;

  pent_sync_edge #(
    .W      (3),
    .ACTIVE (3'b001)
  ) u_io (
    .clk   (CLK_14MHZ),
    .rst   (RESET),
    .strb  ({bus.CPU_IORQ, bus.CPU_WR, bus.CPU_M1}),
    .pulse (io_ev)
  );

  pent_sync_edge #(
    .W      (2),
    .ACTIVE (2'b00)
  ) u_fetch (
    .clk   (CLK_14MHZ),
    .rst   (RESET),
    .strb  ({bus.CPU_MREQ, bus.CPU_M1}),
    .pulse (fetch_ev)
  );

  // Extra page bits live in D7..D5; the 1M board spends D5 on
  // paging, so it has no lock bit.
  always_comb begin
    ext_d  = '0;
    lock_d = bus.D[5];
    unique case (1'b1)
      (RAM_KB == 256):  ext_d = {2'b00, bus.D[6]};
      (RAM_KB == 512):  ext_d = {1'b0, bus.D[7:6]};
      (RAM_KB == 1024): begin
        ext_d  = bus.D[7:5];
        lock_d = 1'b0;
      end
      default: ext_d = '0;
    endcase
  end

  assign port_hit = (FULL_DECODE != 0) ?
                    (bus.A == PORT_7FFD) :
                    (!bus.A[15] && !bus.A[1]);

  assign wr_en = io_ev && port_hit && !locked;

  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      bank   <= '0;
      ext    <= '0;
      rom    <= 1'b0;
      screen <= 1'b0;
      locked <= 1'b0;
      dos    <= 1'b0;
    end else begin
      if (wr_en) begin
        bank   <= bus.D[2:0];
        screen <= bus.D[3];
        rom    <= bus.D[4];
        ext    <= ext_d;
        locked <= lock_d;
      end
      if (fetch_ev) begin
        if (bus.A[15:8] == DOS_HI && rom)
          dos <= 1'b1;
        else if (bus.A[15:14] != 2'b00)
          dos <= 1'b0;
      end
    end
  end

  assign page_hi = {ext, bank};

  always_comb begin
    page_q = '0;
    unique case (bus.A[15:14])
      2'b01:   page_q = PAGE_BITS'(5);
      2'b10:   page_q = PAGE_BITS'(2);
      2'b11:   page_q = PAGE_BITS'(page_hi);
      default: page_q = '0;
    endcase
  end

  assign bus.PAGE     = page_q;
  assign bus.RAM_SEL  = |bus.A[15:14];
  assign bus.ROM_BANK = dos ? ROMDOS :
                        (rom ? ROM48 : ROM128);
  assign bus.SCREEN   = screen;
  assign bus.DOS      = dos;
  assign bus.LOCKED   = locked;

endmodule

// File: tb/tb_pent_mem_pager.sv
// Scoreboard bench: four pager configurations share one Z80 bus
// and are checked against an arithmetic model of the port rules.
module tb_pent_mem_pager;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  d;
  logic        iorq, wr, mreq, m1;
  logic        probe;

  always #5 clk = ~clk;

  pent_mem_pager_if #(.RAM_KB(512))  b0 ();
  pent_mem_pager_if #(.RAM_KB(128))  b1 ();
  pent_mem_pager_if #(.RAM_KB(1024)) b2 ();
  pent_mem_pager_if #(.RAM_KB(256))  b3 ();

  assign b0.A = a;  assign b0.D = d;
  assign b0.CPU_IORQ = iorq;  assign b0.CPU_WR = wr;
  assign b0.CPU_MREQ = mreq;  assign b0.CPU_M1 = m1;
  assign b1.A = a;  assign b1.D = d;
  assign b1.CPU_IORQ = iorq;  assign b1.CPU_WR = wr;
  assign b1.CPU_MREQ = mreq;  assign b1.CPU_M1 = m1;
  assign b2.A = a;  assign b2.D = d;
  assign b2.CPU_IORQ = iorq;  assign b2.CPU_WR = wr;
  assign b2.CPU_MREQ = mreq;  assign b2.CPU_M1 = m1;
  assign b3.A = a;  assign b3.D = d;
  assign b3.CPU_IORQ = iorq;  assign b3.CPU_WR = wr;
  assign b3.CPU_MREQ = mreq;  assign b3.CPU_M1 = m1;

  pent_mem_pager #(.RAM_KB(512), .FULL_DECODE(0)) u0 (
    .CLK_14MHZ(clk), .RESET(rst), .bus(b0));
  pent_mem_pager #(.RAM_KB(128), .FULL_DECODE(0)) u1 (
    .CLK_14MHZ(clk), .RESET(rst), .bus(b1));
  pent_mem_pager #(.RAM_KB(1024), .FULL_DECODE(0)) u2 (
    .CLK_14MHZ(clk), .RESET(rst), .bus(b2));
  pent_mem_pager #(.RAM_KB(256), .FULL_DECODE(1)) u3 (
    .CLK_14MHZ(clk), .RESET(rst), .bus(b3));

  // {PAGE(6), RAM_SEL, ROM_BANK(2), SCREEN, DOS, LOCKED}
  logic [11:0] got [4];
  assign got[0] = {6'(b0.PAGE), b0.RAM_SEL, b0.ROM_BANK,
                   b0.SCREEN, b0.DOS, b0.LOCKED};
  assign got[1] = {6'(b1.PAGE), b1.RAM_SEL, b1.ROM_BANK,
                   b1.SCREEN, b1.DOS, b1.LOCKED};
  assign got[2] = {6'(b2.PAGE), b2.RAM_SEL, b2.ROM_BANK,
                   b2.SCREEN, b2.DOS, b2.LOCKED};
  assign got[3] = {6'(b3.PAGE), b3.RAM_SEL, b3.ROM_BANK,
                   b3.SCREEN, b3.DOS, b3.LOCKED};

  int kb [4] = '{512, 128, 1024, 256};
  bit fd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [7:0] m_d   [4];
  bit         m_lk  [4];
  bit         m_dos [4];

  logic [11:0] exp_q [$];
  logic [15:0] adr_q [$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_d[k] = 8'h00;
      m_lk[k] = 1'b0;
      m_dos[k] = 1'b0;
    end
  endfunction

  function automatic logic [11:0] expect_out(
    input int k, input logic [15:0] pa);
    int hi, pg, pgo;
    logic [1:0] rb;
    if (kb[k] == 1024) hi = (int'(m_d[k]) >> 5) & 7;
    else               hi = (int'(m_d[k]) >> 6) & 3;
    pg = ((int'(m_d[k]) & 7) + 8 * hi) % (kb[k] / 16);
    case (pa[15:14])
      2'd0:    pgo = 0;
      2'd1:    pgo = 5;
      2'd2:    pgo = 2;
      default: pgo = pg;
    endcase
    rb = m_dos[k] ? 2'd2 : {1'b0, m_d[k][4]};
    return {6'(pgo), pa[15:14] != 2'd0, rb,
            m_d[k][3], m_dos[k], m_lk[k]};
  endfunction

  always @(negedge clk) begin
    if (probe) begin
      for (int k = 0; k < 4; k++) begin
        logic [11:0] e;
        logic [15:0] pa;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty dut%0d", k);
        end else begin
          e  = exp_q.pop_front();
          pa = adr_q.pop_front();
          if (got[k] !== e) begin
            n_fail++;
            $display("FAIL probe dut%0d A=%h got=%h exp=%h",
                     k, pa, got[k], e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [15:0] ad,
                          input logic [7:0] dt);
    bit hit;
    @(negedge clk);
    a = ad; d = dt; m1 = 1'b1;
    iorq = 1'b0; wr = 1'b0;
    tick(4);
    iorq = 1'b1; wr = 1'b1;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      if (fd[k]) hit = (ad == 16'h7FFD);
      else       hit = (ad < 16'h8000) && ((ad & 16'h2) == 0);
      if (hit && !m_lk[k]) begin
        m_d[k]  = dt;
        m_lk[k] = (kb[k] < 1024) && dt[5];
      end
    end
  endtask

  task automatic fetch(input logic [15:0] ad);
    @(negedge clk);
    a = ad; m1 = 1'b0; mreq = 1'b0;
    tick(4);
    mreq = 1'b1; m1 = 1'b1;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      if ((ad >> 8) == 16'h3D && m_d[k][4]) m_dos[k] = 1'b1;
      else if (ad >= 16'h4000)              m_dos[k] = 1'b0;
    end
  endtask

  task automatic mem_read(input logic [15:0] ad);
    @(negedge clk);
    a = ad; m1 = 1'b1; mreq = 1'b0;
    tick(4);
    mreq = 1'b1;
    tick(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    model_reset();
  endtask

  task automatic check_at(input logic [15:0] ad);
    @(negedge clk);
    a = ad;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(expect_out(k, ad));
      adr_q.push_back(ad);
    end
    @(posedge clk); #1 probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  // Reset lands on the edge where the write would commit,
  // and the strobe is still low when reset lets go.
  task automatic reset_collide(input logic [7:0] dt);
    @(negedge clk);
    a = 16'h7FFD; d = dt; m1 = 1'b1;
    iorq = 1'b0; wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);
    iorq = 1'b1; wr = 1'b1;
    tick(4);
    model_reset();
  endtask

  logic [15:0] ra;
  logic [7:0]  rd;

  initial begin
    rst = 1'b1; probe = 1'b0;
    a = '0; d = '0;
    iorq = 1'b1; wr = 1'b1; mreq = 1'b1; m1 = 1'b1;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(4);

    check_at(16'hC000);
    check_at(16'h0000);
    check_at(16'h4000);
    check_at(16'h8000);

    io_write(16'h7FFD, 8'hC7);
    check_at(16'hC000);
    io_write(16'h7FFD, 8'hE5);
    check_at(16'hC123);
    io_write(16'h7FFD, 8'h01);
    check_at(16'hC000);
    do_reset();

    io_write(16'h7FFD, 8'h20);
    io_write(16'h7FFD, 8'h03);
    check_at(16'hC000);
    do_reset();
    io_write(16'h7FFD, 8'h03);
    check_at(16'hC000);

    io_write(16'h3FFD, 8'h05);
    check_at(16'hC000);
    io_write(16'h7FFC, 8'h0E);
    check_at(16'hFFFF);

    io_write(16'h7FFD, 8'h10);
    fetch(16'h3D2F);
    check_at(16'h0000);
    fetch(16'h8000);
    check_at(16'h0000);
    mem_read(16'h3D00);
    check_at(16'h0000);
    io_write(16'h7FFD, 8'h00);
    fetch(16'h3D2F);
    check_at(16'h0000);

    io_write(16'h7FFD, 8'h1F);
    check_at(16'hC000);
    reset_collide(8'h0A);
    check_at(16'hC000);
    check_at(16'h0000);

    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 16'h7FFD;
        1:       ra = 16'h3FFD;
        2:       ra = 16'h7FFC;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: io_write(ra, rd);
        4:          fetch({8'h3D, rd});
        5:          fetch(16'($urandom));
        6:          mem_read({8'h3D, rd});
        7:          do_reset();
        default:    tick(1);
      endcase
      check_at(16'($urandom));
    end

    tick(3);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d exp=0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pent_mem_pager.md
PENT_MEM_PAGER -- requirements
Module: pent_mem_pager

Interface
REQ-001 Parameter RAM_KB, default 512: installed RAM size; legal values 128, 256, 512, 1024.
REQ-002 Parameter FULL_DECODE, default 0: 0 decodes port 7FFD as A15=0 and A1=0; 1 requires A==16'h7FFD.
REQ-003 Derived constant PAGE_BITS: 3/4/5/6 for RAM_KB 128/256/512/1024.
REQ-004 CLK_14MHZ  in  1  the only clock.
REQ-005 RESET  in  1  synchronous reset, active-high.
REQ-006 A  in  16  CPU address bus.
REQ-007 D  in  8  CPU data bus, write direction only.
REQ-008 CPU_IORQ, CPU_WR, CPU_MREQ, CPU_M1  in  1 each  Z80 strobes, active-low, asynchronous to CLK_14MHZ.
REQ-009 PAGE  out  PAGE_BITS  RAM page for the current A[15:14].
REQ-010 RAM_SEL  out  1  high when A[15:14]!=00.
REQ-011 ROM_BANK  out  2  ROM bank index: 0 = 128 BASIC, 1 = 48 BASIC, 2 = TR-DOS.
REQ-012 SCREEN  out  1  selects screen page 7 when high and page 5 when low.
REQ-013 DOS  out  1  TR-DOS shadow active.
REQ-014 LOCKED  out  1  7FFD lock latched.

Function
REQ-015 Each strobe SHALL pass through a 2-flop synchroniser; events are the falling edges of the synchronised composites.
REQ-016 IO-write event: IORQ low and WR low and M1 high, with the port decode per FULL_DECODE; one CLK_14MHZ pulse per Z80 cycle.
REQ-017 Fetch event: MREQ low and M1 low; one pulse per opcode fetch.
REQ-018 A and D SHALL be sampled in the event cycle; the register updates on the next edge (latency 3 clocks from the strobe fall).
REQ-019 Write fields: bank[2:0]=D[2:0], SCREEN=D3, rom=D4.
REQ-020 Lock field: LOCKED=D5 for RAM_KB<1024.
REQ-021 Extension fields: 256 uses D6 as page bit 3; 512 uses D7:D6 as bits 4:3; 1024 uses D7:D5 as bits 5:3, and LOCKED is held at 0.
REQ-022 While LOCKED=1, 7FFD writes SHALL be ignored entirely until RESET.
REQ-023 DOS entry: a fetch event with A[15:8]==8'h3D and rom=1 sets DOS on the next edge.
REQ-024 DOS exit: a fetch event with A[15:14]!=00 clears DOS on the next edge.
REQ-025 DOS is set or cleared only by fetch events, never by data reads or refresh.
REQ-026 Mapping, combinational from the registers and A[15:14]:
  - 00: RAM_SEL=0, ROM_BANK = DOS ? 2 : {0,rom}.
  - 01: PAGE=5.
  - 10: PAGE=2.
  - 11: PAGE={ext,bank}.
REQ-027 PAGE SHALL be zero-extended to PAGE_BITS and upper ext bits masked to RAM_KB, so that no page outside the installed RAM is output.
REQ-028 An IO-write event and a fetch event in the same cycle SHALL both take effect independently.
REQ-029 Back-to-back writes: the last write wins; no write is lost at the minimum Z80 IO spacing.

Reset
REQ-030 RESET SHALL clear bank, ext, rom, SCREEN, LOCKED, DOS and the synchroniser/edge flops; PAGE reads 0 for A[15:14]=11.
REQ-031 RESET SHALL win over any simultaneous event.
REQ-032 A strobe still low when RESET deasserts SHALL NOT produce an event.

Structure
REQ-033 Package pent_pkg SHALL hold:
  - the RAM_KB-to-PAGE_BITS function;
  - the ROM_BANK constants ROM128, ROM48, ROMDOS;
  - PORT_7FFD and the DOS entry high byte 8'h3D.
REQ-034 One sub-module, pent_sync_edge (2-flop synchroniser plus falling-edge pulse), SHALL be instantiated twice: once for IO write, once for fetch.

Verification
REQ-035 RAM_KB=512: OUT 7FFD,0xC7 -> A=C000 gives PAGE=31, SCREEN=0, LOCKED=0.
REQ-036 RAM_KB=128: OUT 7FFD,0x20 then OUT 7FFD,0x03 -> LOCKED=1 and PAGE=0 at C000; after RESET, the same OUT 0x03 gives PAGE=3.
REQ-037 rom=1, fetch at 3D2F -> DOS=1 and ROM_BANK=2; then fetch at 8000 -> DOS=0 and ROM_BANK=1.
REQ-038 rom=0, fetch at 3D2F -> DOS stays 0.
REQ-039 rom=1, memory read (M1 high) at 3D00 -> DOS stays 0.
REQ-040 RAM_KB=1024: OUT 7FFD,0xE5 -> PAGE=61 and LOCKED=0; a second OUT 0x01 -> PAGE=1.
REQ-041 FULL_DECODE=1: OUT to 0x7FFC or 0x3FFD -> no change.
REQ-042 FULL_DECODE=0: OUT to 0x3FFD -> register updated.
REQ-043 RESET asserted in the same cycle as an IO-write event -> all outputs at reset values.
REQ-044 RESET asserted in the same cycle as an IO-write event -> no update on the following edge.
